user_sbr_demux: RTL and testbench

USER_SBR_DEMUX -- requirements
Module: user_sbr_demux

---
 rtl/croc_pkg.sv | 8 +
 rtl/user_pkg.sv | 20 ++
 rtl/user_err_sbr.sv | 23 ++
 rtl/user_sbr_demux.sv | 121 ++++++++++++
 tb/tb_user_sbr_demux.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/croc_pkg.sv
// croc_pkg: shared platform types; the address map rule format used by every demux in the SoC
package croc_pkg;
    typedef struct packed {
        int unsigned idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;
endpackage

// File: rtl/user_pkg.sv
// user_pkg: parameter defaults, demux output indices and address constants of the user subordinate demux
package user_pkg;
    localparam int unsigned NumDemuxSbr = 2;
    localparam int unsigned NumDemuxRules = 2;
    localparam int unsigned DemuxMaxOutstanding = 4;
    localparam logic [31:0] DemuxErrData = 32'hBADC_AB1E;
    typedef enum int unsigned {
        UserError = 0,
        UserSbr1 = 1,
        UserSbr2 = 2
    } user_demux_outputs_e;
    localparam logic [31:0] UserSbr1Start = 32'h2000_0000;
    localparam logic [31:0] UserSbr1End = 32'h2001_0000;
    localparam logic [31:0] UserSbr2Start = 32'h2001_0000;
    localparam logic [31:0] UserSbr2End = 32'h2002_0000;
    localparam croc_pkg::addr_map_rule_t [NumDemuxRules-1:0] UserAddrMap = '{
        1: '{idx: UserSbr2, start_addr: UserSbr2Start, end_addr: UserSbr2End},
        0: '{idx: UserSbr1, start_addr: UserSbr1Start, end_addr: UserSbr1End}
    };
endpackage

// File: rtl/user_err_sbr.sv
// user_err_sbr: error subordinate; grants at once and answers with an error one cycle later
module user_err_sbr
    import user_pkg::*;
#(
    parameter logic [31:0] ErrData = DemuxErrData
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);
    logic rvalid_q;
    always_ff @(posedge clk_i) begin
        rvalid_q <= rst_i ? 1'b0 : req_i;
    end
    assign gnt_o = req_i;
    assign rvalid_o = rvalid_q;
    assign err_o = rvalid_q;
    assign rdata_o = rvalid_q ? ErrData : '0;
endmodule

// File: rtl/user_sbr_demux.sv
// user_sbr_demux: address-decoded manager-to-subordinate demux with an internal error subordinate.
// Optional USER_DEMUX_ERR_CAPTURE_EN adds a sticky error interrupt and captured error address.
module user_sbr_demux
    import user_pkg::*;
#(
    parameter int unsigned NumSbr = NumDemuxSbr,
    parameter int unsigned NumRules = NumDemuxRules,
    parameter croc_pkg::addr_map_rule_t [NumRules-1:0] AddrMap = '0,
    parameter int unsigned MaxOutstanding = DemuxMaxOutstanding,
    parameter logic [31:0] ErrData = DemuxErrData
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mgr_req_i,
    input  logic                   mgr_we_i,
    input  logic [31:0]            mgr_addr_i,
    input  logic [3:0]             mgr_be_i,
    input  logic [31:0]            mgr_wdata_i,
    output logic                   mgr_gnt_o,
    output logic                   mgr_rvalid_o,
    output logic                   mgr_err_o,
    output logic [31:0]            mgr_rdata_o,
    output logic [NumSbr-1:0]      sbr_req_o,
    output logic [31:0]            sbr_addr_o,
    output logic [31:0]            sbr_wdata_o,
    output logic                   sbr_we_o,
    output logic [3:0]             sbr_be_o,
    input  logic [NumSbr-1:0]      sbr_gnt_i,
    input  logic [NumSbr-1:0]      sbr_rvalid_i,
    input  logic [NumSbr-1:0]      sbr_err_i,
    input  logic [NumSbr-1:0][31:0] sbr_rdata_i
`ifdef USER_DEMUX_ERR_CAPTURE_EN
    ,
    input  logic                   err_clr_i,
    output logic                   err_irq_o,
    output logic [31:0]            err_addr_o
`endif
);
    localparam int unsigned TgtW = $clog2(NumSbr + 1);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [0:0] Idle = 1'b0;
    localparam logic [0:0] Active = 1'b1;
    logic [TgtW-1:0] dec, locked_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [0:0] state_q;
    logic allow, fwd, err_req, err_gnt, err_rvalid, err_err;
    logic rv_sel, er_sel, rv;
    logic [31:0] err_rdata, rd_sel;
    // Descending scan so the lowest-indexed matching rule overrides the rest
    always_comb begin
        dec = '0;
        for (int r = int'(NumRules) - 1; r >= 0; r--)
            if (mgr_addr_i >= AddrMap[r].start_addr && mgr_addr_i < AddrMap[r].end_addr)
                dec = TgtW'(AddrMap[r].idx);
    end
    assign allow = state_q == Idle || (dec == locked_q && cnt_q < CntW'(MaxOutstanding));
    assign fwd = mgr_req_i && allow && !rst_i;
    assign err_req = fwd && dec == '0;
    always_comb begin
        sbr_req_o = '0;
        for (int i = 0; i < int'(NumSbr); i++)
            sbr_req_o[i] = fwd && dec == TgtW'(i + 1);
    end
    assign mgr_gnt_o = err_gnt | |(sbr_req_o & sbr_gnt_i);
    assign sbr_addr_o = rst_i ? '0 : mgr_addr_i;
    assign sbr_wdata_o = rst_i ? '0 : mgr_wdata_i;
    assign sbr_we_o = mgr_we_i && !rst_i;
    assign sbr_be_o = rst_i ? '0 : mgr_be_i;
    user_err_sbr #(.ErrData(ErrData)) i_err_sbr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (err_req),
        .gnt_o   (err_gnt),
        .rvalid_o(err_rvalid),
        .err_o   (err_err),
        .rdata_o (err_rdata)
    );
    always_comb begin
        rv_sel = err_rvalid;
        er_sel = err_err;
        rd_sel = err_rdata;
        for (int i = 0; i < int'(NumSbr); i++)
            if (locked_q == TgtW'(i + 1)) begin
                rv_sel = sbr_rvalid_i[i];
                er_sel = sbr_err_i[i];
                rd_sel = sbr_rdata_i[i];
            end
    end
    // Responses only count while something is outstanding, so stale rvalids after reset vanish
    assign rv = rv_sel && state_q == Active && !rst_i;
    assign mgr_rvalid_o = rv;
    assign mgr_err_o = rv && er_sel;
    assign mgr_rdata_o = rv ? rd_sel : '0;
    assign cnt_d = cnt_q + CntW'(mgr_gnt_o) - CntW'(rv);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            state_q <= Idle;
            locked_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            state_q <= cnt_d == '0 ? Idle : Active;
            if (mgr_gnt_o) locked_q <= dec;
        end
    end
`ifdef USER_DEMUX_ERR_CAPTURE_EN
    logic irq_q;
    logic [31:0] addr_q;
    always_ff @(posedge clk_i) begin
        if (rst_i || err_clr_i) begin
            irq_q <= 1'b0;
            addr_q <= '0;
        end else if (err_gnt && !irq_q) begin
            irq_q <= 1'b1;
            addr_q <= mgr_addr_i;
        end
    end
    assign err_irq_o = irq_q && !rst_i;
    assign err_addr_o = rst_i ? '0 : addr_q;
`endif
endmodule

// File: tb/tb_user_sbr_demux.sv
// tb_user_sbr_demux: directed and random stimulus against a transaction-queue reference of the demux
module tb_user_sbr_demux;
    import croc_pkg::*;
    import user_pkg::*;
    localparam int NS = 2;
    localparam int NR = 2;
    localparam int MO = 4;
    localparam logic [31:0] ED = 32'hBADC_AB1E;
    // Rule 1 overlaps rule 0 from 0x2000_8000 so lowest-index priority is exercised
    localparam addr_map_rule_t [NR-1:0] Map = '{
        1: '{idx: 2, start_addr: 32'h2000_8000, end_addr: 32'h2002_0000},
        0: '{idx: 1, start_addr: 32'h2000_0000, end_addr: 32'h2001_0000}
    };
    logic clk = 1'b0;
    logic rst, req, we;
    logic [31:0] addr, wdata;
    logic [3:0] be;
    logic gnt, rvalid, err;
    logic [31:0] rdata, s_addr, s_wdata;
    logic [NS-1:0] s_req, s_gnt, s_rvalid, s_err;
    logic s_we;
    logic [3:0] s_be;
    logic [NS-1:0][31:0] s_rdata;
    logic [31:0] pool [12] = '{32'h2000_1004, 32'h2000_0000, 32'h2000_7FFF, 32'h2000_8000,
                              32'h2000_FFFF, 32'h2001_0000, 32'h2001_FFFF, 32'h2002_0000,
                              32'h1FFF_FFFF, 32'h3000_0000, 32'h2001_4000, 32'h0000_0000};
    int checks = 0;
    int errors = 0;
    int q[$];
    int locked = 0;
    bit err_pend = 0;
`ifdef USER_DEMUX_ERR_CAPTURE_EN
    logic clr, irq;
    logic [31:0] cap;
    bit m_irq = 0;
    logic [31:0] m_cap = '0;
`endif
    always #5 clk = ~clk;
    user_sbr_demux #(.NumSbr(NS), .NumRules(NR), .AddrMap(Map), .MaxOutstanding(MO), .ErrData(ED)) dut (
        .clk_i(clk), .rst_i(rst), .mgr_req_i(req), .mgr_we_i(we), .mgr_addr_i(addr),
        .mgr_be_i(be), .mgr_wdata_i(wdata), .mgr_gnt_o(gnt), .mgr_rvalid_o(rvalid),
        .mgr_err_o(err), .mgr_rdata_o(rdata), .sbr_req_o(s_req), .sbr_addr_o(s_addr),
        .sbr_wdata_o(s_wdata), .sbr_we_o(s_we), .sbr_be_o(s_be), .sbr_gnt_i(s_gnt),
        .sbr_rvalid_i(s_rvalid), .sbr_err_i(s_err), .sbr_rdata_i(s_rdata)
`ifdef USER_DEMUX_ERR_CAPTURE_EN
        , .err_clr_i(clr), .err_irq_o(irq), .err_addr_o(cap)
`endif
    );
    function automatic int ref_dec(logic [31:0] a);
        for (int r = 0; r < NR; r++)
            if (a >= Map[r].start_addr && a < Map[r].end_addr) return int'(Map[r].idx);
        return 0;
    endfunction
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic step();
        int d;
        bit busy, allow, fwd, eg, rv, er;
        logic [31:0] rd;
        logic [NS-1:0] ereq;
        #2;
        d = ref_dec(addr);
        busy = q.size() > 0;
        allow = !busy || (d == locked && q.size() < MO);
        fwd = req && allow && !rst;
        ereq = '0;
        if (fwd && d > 0) ereq[d-1] = 1'b1;
        eg = fwd && (d == 0 || s_gnt[d-1]);
        rv = 0; er = 0; rd = '0;
        if (busy && !rst) begin
            if (locked == 0) begin
                rv = err_pend; er = 1; rd = ED;
            end else begin
                rv = s_rvalid[locked-1]; er = s_err[locked-1]; rd = s_rdata[locked-1];
            end
        end
        if (!rv) begin er = 0; rd = '0; end
        chk("sbr_req", 32'(s_req), 32'(ereq));
        chk("mgr_gnt", 32'(gnt), 32'(eg));
        chk("mgr_rvalid", 32'(rvalid), 32'(rv));
        chk("mgr_err", 32'(err), 32'(er));
        chk("mgr_rdata", rdata, rd);
        chk("sbr_addr", s_addr, rst ? 32'h0 : addr);
        chk("sbr_wdata", s_wdata, rst ? 32'h0 : wdata);
        chk("sbr_we_be", {27'h0, s_we, s_be}, rst ? 32'h0 : {27'h0, we, be});
`ifdef USER_DEMUX_ERR_CAPTURE_EN
        chk("err_irq", 32'(irq), 32'(m_irq && !rst));
        chk("err_addr", cap, rst ? 32'h0 : m_cap);
`endif
        @(posedge clk);
        if (rst) begin
            q.delete(); locked = 0; err_pend = 0;
        end else begin
            if (rv) void'(q.pop_front());
            if (eg) begin q.push_back(d); locked = d; end
            err_pend = eg && d == 0;
        end
`ifdef USER_DEMUX_ERR_CAPTURE_EN
        if (rst || clr) begin m_irq = 0; m_cap = '0; end
        else if (eg && d == 0 && !m_irq) begin m_irq = 1; m_cap = addr; end
`endif
        #1;
    endtask
    initial begin
        rst = 1; req = 0; we = 0; addr = '0; wdata = '0; be = '0;
        s_gnt = '0; s_rvalid = '0; s_err = '0; s_rdata = '0;
`ifdef USER_DEMUX_ERR_CAPTURE_EN
        clr = 0;
`endif
        #1; step(); step();
        rst = 0; step();
        // read to sbr1, immediate grant, rvalid next cycle
        req = 1; addr = 32'h2000_1004; s_gnt = 2'b01; step();
        req = 0; s_gnt = '0; s_rvalid = 2'b01; s_rdata[0] = 32'h1234_5678; step();
        s_rvalid = '0; step();
        // unmapped read answered by the error subordinate
        req = 1; addr = 32'h3000_0000; step();
        req = 0; step(); step();
        // outstanding limit, then same-cycle grant and response
        req = 1; addr = 32'h2000_0100; s_gnt = 2'b01; repeat (6) step();
        s_rvalid = 2'b01; step();
        req = 0; repeat (5) step();
        s_rvalid = '0; step();
        // differently-targeted request waits for the last response
        req = 1; addr = 32'h2000_0200; s_gnt = 2'b01; step();
        addr = 32'h2001_4000; s_gnt = 2'b11; step(); step();
        s_rvalid = 2'b01; step();
        s_rvalid = '0; step();
        req = 0; s_rvalid = 2'b10; s_rdata[1] = 32'hCAFE_0002; s_err = 2'b10; step();
        s_rvalid = '0; s_err = '0; step();
        // reset with two in flight drops the late response
        req = 1; addr = 32'h2000_0300; s_gnt = 2'b01; step(); step();
        req = 0; rst = 1; step();
        rst = 0; s_rvalid = 2'b01; step();
        s_rvalid = '0; step();
        // decode boundaries and overlap priority
        for (int i = 0; i < 12; i++) begin
            req = 1; addr = pool[i]; s_gnt = 2'b11; step();
            req = 0; s_rvalid = 2'b11; s_rdata[0] = 32'(i); s_rdata[1] = 32'(i + 100); step();
            s_rvalid = '0; step();
        end
`ifdef USER_DEMUX_ERR_CAPTURE_EN
        req = 1; addr = 32'h3000_0010; step();
        addr = 32'h3000_0020; step();
        req = 0; step();
        clr = 1; req = 1; step();
        clr = 0; req = 0; step(); step();
`endif
        for (int n = 0; n < 800; n++) begin
            rst = $urandom_range(0, 99) == 0;
            req = $urandom_range(0, 3) != 0;
            we = 1'($urandom);
            be = 4'($urandom);
            wdata = $urandom;
            addr = pool[$urandom_range(0, 11)];
            s_gnt = 2'($urandom);
            s_rvalid = {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
            s_err = 2'($urandom);
            s_rdata[0] = $urandom;
            s_rdata[1] = $urandom;
`ifdef USER_DEMUX_ERR_CAPTURE_EN
            clr = $urandom_range(0, 29) == 0;
`endif
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
